// File: rtl/ram_sweep_pkg.sv
// Shared types and helpers for the sweep-cleared R/W RAM.
package ram_sweep_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even.
    // Callers zero-extend their data, so words up to 64 bits are covered.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_sweep_array.sv
// Plain word storage: one write port, one registered read port with enable.
module ram_sweep_array #(
    parameter int unsigned AddrWidth = 2,
    parameter int unsigned Width     = 4,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q, rdata_d;

    // Storage is never reset; the owner sweeps it to zero instead.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_rw_sweep.sv
// Single-port R/W RAM with zero sweep after reset/clear, req/ready handshake and range check.
// Optional per-word even parity when RAM_PARITY_EN is defined.
module ram_rw_sweep
    import ram_sweep_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  addr_err,
    output logic                  parity_err
);

`ifdef RAM_PARITY_EN
    localparam int unsigned MemWidth = DATA_WIDTH + 1;
`else
    localparam int unsigned MemWidth = DATA_WIDTH;
`endif

    ram_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  rvalid_q, rvalid_d;
    logic                  addr_err_q, addr_err_d;
    logic                  oor_q, oor_d;

    logic                  in_range;
    logic                  accept;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [MemWidth-1:0]   mem_wdata;
    logic [MemWidth-1:0]   mem_rdata;

    assign in_range = 32'(addr) < DEPTH;
    assign accept   = (state_q == READY) && req && !clear;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (32'(clr_addr_q) == DEPTH - 1) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clear) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // The sweep owns the write port while clearing; accesses cannot be accepted then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = '0;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
        end else begin
            mem_we = accept && we && in_range;
`ifdef RAM_PARITY_EN
            mem_wdata = {even_parity(64'(wdata)), wdata};
`else
            mem_wdata = wdata;
`endif
        end
    end

    assign mem_re = accept && !we && in_range;

    always_comb begin
        rvalid_d   = accept && !we;
        addr_err_d = accept && !in_range;
        oor_d      = oor_q;
        if (accept && !we) begin
            oor_d = !in_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
            oor_q      <= oor_d;
        end
    end

    ram_sweep_array #(
        .AddrWidth(ADDR_WIDTH),
        .Width    (MemWidth),
        .Depth    (DEPTH)
    ) u_array (
        .clk_i  (clk),
        .rst_ni (reset),
        .we_i   (mem_we),
        .waddr_i(mem_waddr),
        .wdata_i(mem_wdata),
        .re_i   (mem_re),
        .raddr_i(addr),
        .rdata_o(mem_rdata)
    );

    assign ready    = (state_q == READY);
    assign rvalid   = rvalid_q;
    assign addr_err = addr_err_q;
    // Out-of-range reads present zero while the array register keeps its old word.
    assign rdata    = oor_q ? '0 : mem_rdata[DATA_WIDTH-1:0];

`ifdef RAM_PARITY_EN
    assign parity_err = rvalid_q && !oor_q &&
                        (even_parity(64'(mem_rdata[DATA_WIDTH-1:0])) != mem_rdata[DATA_WIDTH]);
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_rw_sweep.sv
// Directed bench for ram_rw_sweep with a read scoreboard; second instance covers DEPTH=3.
module tb_ram_rw_sweep;

    logic       clk = 1'b0;
    logic       reset, clear, req, we;
    logic [1:0] addr;
    logic [3:0] wdata;

    logic       ready, rvalid, addr_err, parity_err;
    logic [3:0] rdata;
    logic       ready3, rvalid3, addr_err3, parity_err3;
    logic [3:0] rdata3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         due;
        logic [3:0] data;
        logic       aerr;
        logic       perr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_rw_sweep dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .addr_err  (addr_err),
        .parity_err(parity_err)
    );

    ram_rw_sweep #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(4),
        .DEPTH     (3)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready3),
        .rdata     (rdata3),
        .rvalid    (rvalid3),
        .addr_err  (addr_err3),
        .parity_err(parity_err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        sync();
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic read(input logic [1:0] a, input logic [3:0] d, input logic ae,
                        input logic pe);
        exp_t e;
        req    = 1'b1;
        we     = 1'b0;
        addr   = a;
        e.due  = cyc + 1;
        e.data = d;
        e.aerr = ae;
        e.perr = pe;
        sb.push_back(e);
        sync();
        req = 1'b0;
    endtask

    // Expect ready low on four consecutive samples, then high.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_ready_low"}, 32'(ready), 32'd0);
        end
        @(negedge clk);
        check({tag, "_ready_high"}, 32'(ready), 32'd1);
        sync();
    endtask

    // Scoreboard: every rvalid must match the oldest outstanding read, on its due cycle.
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("rd_latency", 32'(cyc), 32'(sb[0].due));
                check("rd_data", 32'(rdata), 32'(sb[0].data));
                check("rd_addr_err", 32'(addr_err), 32'(sb[0].aerr));
                check("rd_parity_err", 32'(parity_err), 32'(sb[0].perr));
                sb.delete(0);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("missing_rvalid", 32'd0, 32'd1);
            sb.delete(0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        #2 reset = 1'b0;
        sync();
        sync();
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);

        // Power-up sweep, then everything reads back zero.
        sync();
        reset = 1'b1;
        check_sweep("init");
        for (int a = 0; a < 4; a++) read(2'(a), 4'h0, 1'b0, 1'b0);
        sync();
        sync();

        // Back-to-back writes, back-to-back reads.
        write(2'd1, 4'hA);
        write(2'd2, 4'h5);
        read(2'd1, 4'hA, 1'b0, 1'b0);
        read(2'd2, 4'h5, 1'b0, 1'b0);
        sync();
        sync();

        // Out-of-range on the DEPTH=3 instance (address 3 is legal on the main one).
        write(2'd3, 4'hF);
        @(negedge clk);
        check("oor_wr_addr_err", 32'(addr_err3), 32'd1);
        check("oor_wr_no_rvalid", 32'(rvalid3), 32'd0);
        sync();
        @(negedge clk);
        check("oor_addr_err_pulse", 32'(addr_err3), 32'd0);
        sync();
        read(2'd3, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        check("oor_rd_rvalid", 32'(rvalid3), 32'd1);
        check("oor_rd_rdata", 32'(rdata3), 32'd0);
        check("oor_rd_addr_err", 32'(addr_err3), 32'd1);
        check("oor_rd_parity", 32'(parity_err3), 32'd0);
        sync();
        sync();

        // Clear wins over a same-cycle request.
        for (int a = 0; a < 4; a++) write(2'(a), 4'hF);
        clear = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 2'd1;
        sync();
        clear = 1'b0;
        req   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("clr_ready_low", 32'(ready), 32'd0);
        end
        @(negedge clk);
        check("clr_ready_high", 32'(ready), 32'd1);
        sync();
        for (int a = 0; a < 4; a++) read(2'(a), 4'h0, 1'b0, 1'b0);
        sync();
        sync();

        // Reset in the middle of a clear sweep.
        write(2'd3, 4'h9);
        read(2'd3, 4'h9, 1'b0, 1'b0);
        sync();
        @(negedge clk);
        check("rdata_holds", 32'(rdata), 32'h9);
        sync();
        clear = 1'b1;
        sync();
        clear = 1'b0;
        sync();
        sync();
        reset = 1'b0;
        #1;
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        sync();
        reset = 1'b1;
        check_sweep("restart");
        read(2'd3, 4'h0, 1'b0, 1'b0);
        read(2'd0, 4'h0, 1'b0, 1'b0);
        sync();
        sync();

`ifdef RAM_PARITY_EN
        write(2'd0, 4'h3);
        dut.u_array.mem_q[0][0] = ~dut.u_array.mem_q[0][0];
        read(2'd0, 4'h2, 1'b0, 1'b1);
        sync();
        sync();
`endif

        sync();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
